// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the MIPS instruction-fetch front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mips_fetch_pkg;

  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_INST_WIDTH = 32;

  // Instruction addresses are word aligned; low two bits always cleared.
  localparam logic [31:0] PC_ALIGN_MASK = ~32'h3;

  // Value held in instruction registers when nothing has been fetched.
  localparam logic [31:0] INST_NOP = 32'h0;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry holding register for a fetched {pc, pc_plus4, inst} tuple.
// Latency: pushed entry is visible on the outputs the cycle after push.
// Backpressure: none internally; caller must only push when empty or popping.
//
// Ports:
//   core_clk_i, rst_n_i      clock, synchronous active-low reset
//   clear_i                  drop the held entry (wins over push/pop)
//   push_i / pop_i           load a new entry / release the held entry
//   pc_i, pc_plus4_i, inst_i entry to store
//   full_o                   an entry is held
//   pc_o, pc_plus4_o, inst_o held entry
module fetch_skid_buffer
  import mips_fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int INST_WIDTH = DEF_INST_WIDTH
) (
  input  logic                  core_clk_i,
  input  logic                  rst_n_i,
  input  logic                  clear_i,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [ADDR_WIDTH-1:0] pc_i,
  input  logic [ADDR_WIDTH-1:0] pc_plus4_i,
  input  logic [INST_WIDTH-1:0] inst_i,
  output logic                  full_o,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic [ADDR_WIDTH-1:0] pc_plus4_o,
  output logic [INST_WIDTH-1:0] inst_o
);

  logic                  full_q, full_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] pc4_q, pc4_d;
  logic [INST_WIDTH-1:0] inst_q, inst_d;

  // Push takes precedence over pop so a simultaneous pop+push keeps the
  // buffer full with the newer entry.
  always_comb begin
    full_d = full_q;
    pc_d   = pc_q;
    pc4_d  = pc4_q;
    inst_d = inst_q;
    if (clear_i) begin
      full_d = 1'b0;
    end else if (push_i) begin
      full_d = 1'b1;
      pc_d   = pc_i;
      pc4_d  = pc_plus4_i;
      inst_d = inst_i;
    end else if (pop_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge core_clk_i) begin
    if (!rst_n_i) begin
      full_q <= 1'b0;
      pc_q   <= '0;
      pc4_q  <= '0;
      inst_q <= INST_WIDTH'(INST_NOP);
    end else begin
      full_q <= full_d;
      pc_q   <= pc_d;
      pc4_q  <= pc4_d;
      inst_q <= inst_d;
    end
  end

  assign full_o     = full_q;
  assign pc_o       = pc_q;
  assign pc_plus4_o = pc4_q;
  assign inst_o     = inst_q;

endmodule

// File: rtl/pc_fetch_stage.sv
// MIPS IF stage: PC register, next-PC select, I-mem issue, IF/ID valid/ready output.
// Latency: issue -> IMEM_RDATA next cycle -> IF_VALID the cycle after; redirect -> target on IF_* at +3.
// Backpressure: IF_READY low parks one response in a skid entry and stops issue until it drains.
//
// Ports:
//   CLK, RESET_N                    clock, synchronous active-low reset
//   PC_PLUS4                        external adder result for PC_OUT
//   BRANCH_TAKEN/_TARGET, JUMP/_TARGET  single-cycle redirects (branch wins)
//   STALL                           freeze PC and issue
//   PC_OUT, IMEM_REQ, IMEM_RDATA    instruction memory interface
//   IF_VALID, IF_READY, IF_PC, IF_PC_PLUS4, IF_INST  output handshake to IF/ID
module pc_fetch_stage
  import mips_fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int                    INST_WIDTH = DEF_INST_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic [ADDR_WIDTH-1:0] PC_PLUS4,
  input  logic                  BRANCH_TAKEN,
  input  logic [ADDR_WIDTH-1:0] BRANCH_TARGET,
  input  logic                  JUMP,
  input  logic [ADDR_WIDTH-1:0] JUMP_TARGET,
  input  logic                  STALL,
  output logic [ADDR_WIDTH-1:0] PC_OUT,
  output logic                  IMEM_REQ,
  input  logic [INST_WIDTH-1:0] IMEM_RDATA,
  output logic                  IF_VALID,
  input  logic                  IF_READY,
  output logic [ADDR_WIDTH-1:0] IF_PC,
  output logic [ADDR_WIDTH-1:0] IF_PC_PLUS4,
  output logic [INST_WIDTH-1:0] IF_INST
);

  // Mask built by widening the two cleared bits, so it scales with ADDR_WIDTH.
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(~PC_ALIGN_MASK);

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  infl_q, infl_d;
  logic [ADDR_WIDTH-1:0] tag_pc_q, tag_pc_d;
  logic [ADDR_WIDTH-1:0] tag_pc4_q, tag_pc4_d;
  logic                  out_vld_q, out_vld_d;
  logic [ADDR_WIDTH-1:0] out_pc_q, out_pc_d;
  logic [ADDR_WIDTH-1:0] out_pc4_q, out_pc4_d;
  logic [INST_WIDTH-1:0] out_inst_q, out_inst_d;

  logic                  redirect;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  out_free;
  logic                  skid_full, skid_push, skid_pop, resp_to_out;
  logic [ADDR_WIDTH-1:0] skid_pc, skid_pc4;
  logic [INST_WIDTH-1:0] skid_inst;
  logic                  imem_req;

  // Branch resolves an older instruction than a jump, so it wins.
  assign redirect    = BRANCH_TAKEN | JUMP;
  assign redirect_pc = (BRANCH_TAKEN ? BRANCH_TARGET : JUMP_TARGET) & ALIGN_MASK;

  // Output register can take a new entry if empty or being drained now.
  assign out_free    = !out_vld_q || IF_READY;
  // Skid always drains first; a response lands behind it or, if the
  // output is blocked, parks in it. Redirect discards everything.
  assign skid_pop    = !redirect && skid_full && out_free;
  assign skid_push   = !redirect && infl_q && (skid_full || !out_free);
  assign resp_to_out = !redirect && infl_q && !skid_full && out_free;

  fetch_skid_buffer #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .INST_WIDTH (INST_WIDTH)
  ) u_skid (
    .core_clk_i (CLK),
    .rst_n_i    (RESET_N),
    .clear_i    (redirect),
    .push_i     (skid_push),
    .pop_i      (skid_pop),
    .pc_i       (tag_pc_q),
    .pc_plus4_i (tag_pc4_q),
    .inst_i     (IMEM_RDATA),
    .full_o     (skid_full),
    .pc_o       (skid_pc),
    .pc_plus4_o (skid_pc4),
    .inst_o     (skid_inst)
  );

  // FSM: state register
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (redirect) begin
      state_d = FETCH;
    end else begin
      unique case (state_q)
        BOOT:    state_d = FETCH;
        FETCH:   if (skid_push) state_d = HOLD;
        HOLD:    if (skid_pop && !skid_push) state_d = FETCH;
        default: state_d = BOOT;
      endcase
    end
  end

  // FSM: outputs. Issue is also withheld in the cycle a response is
  // parking in the skid: the next response would have nowhere to go if
  // IF_READY stays low.
  always_comb begin
    imem_req = 1'b0;
    if (state_q == FETCH && !skid_full && !skid_push && !STALL && !redirect) begin
      imem_req = 1'b1;
    end
  end

  // Datapath next state
  always_comb begin
    pc_d       = pc_q;
    infl_d     = imem_req;
    tag_pc_d   = tag_pc_q;
    tag_pc4_d  = tag_pc4_q;
    out_vld_d  = out_vld_q;
    out_pc_d   = out_pc_q;
    out_pc4_d  = out_pc4_q;
    out_inst_d = out_inst_q;

    if (redirect) begin
      pc_d = redirect_pc;
    end else if (imem_req) begin
      pc_d = PC_PLUS4;
    end

    if (imem_req) begin
      tag_pc_d  = pc_q;
      tag_pc4_d = PC_PLUS4;
    end

    if (redirect) begin
      out_vld_d = 1'b0;
    end else if (skid_pop) begin
      out_vld_d  = 1'b1;
      out_pc_d   = skid_pc;
      out_pc4_d  = skid_pc4;
      out_inst_d = skid_inst;
    end else if (resp_to_out) begin
      out_vld_d  = 1'b1;
      out_pc_d   = tag_pc_q;
      out_pc4_d  = tag_pc4_q;
      out_inst_d = IMEM_RDATA;
    end else if (IF_READY) begin
      out_vld_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      pc_q       <= RESET_PC;
      infl_q     <= 1'b0;
      tag_pc_q   <= '0;
      tag_pc4_q  <= '0;
      out_vld_q  <= 1'b0;
      out_pc_q   <= '0;
      out_pc4_q  <= '0;
      out_inst_q <= INST_WIDTH'(INST_NOP);
    end else begin
      pc_q       <= pc_d;
      infl_q     <= infl_d;
      tag_pc_q   <= tag_pc_d;
      tag_pc4_q  <= tag_pc4_d;
      out_vld_q  <= out_vld_d;
      out_pc_q   <= out_pc_d;
      out_pc4_q  <= out_pc4_d;
      out_inst_q <= out_inst_d;
    end
  end

  assign PC_OUT      = pc_q;
  assign IMEM_REQ    = imem_req;
  assign IF_VALID    = out_vld_q;
  assign IF_PC       = out_pc_q;
  assign IF_PC_PLUS4 = out_pc4_q;
  assign IF_INST     = out_inst_q;

endmodule
